serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
- Bit-serial sequencer that sits directly upstream of the single-bit full_adder and drives its a, b and cin inputs.
- Accepts two WIDTH-bit operands plus carry-in and presents one operand bit pair per cycle, LSB first.
- Holds the ripple carry in a flop between cycles and shifts the full adder's sum back into a result register.
- Reports the WIDTH-bit sum and carry-out with a one-cycle done pulse. The full adder stays external and combinational.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a_in  input  WIDTH  operand A; latched on the edge that accepts start.
- b_in  input  WIDTH  operand B; latched with a_in.
- cin_in  input  1  initial carry-in; latched with a_in.
- fa_a  output  1  to full_adder a: current LSB of the A shift register.
- fa_b  output  1  to full_adder b: current LSB of the B shift register.
- fa_cin  output  1  to full_adder cin: the carry flop.
- fa_sum  input  1  from full_adder sum.
- fa_cout  input  1  from full_adder cout.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse; result is valid.
- sum_out  output  WIDTH  result; holds until the next accepted start.
- cout_out  output  1  final carry-out; holds with sum_out.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - Shift registers, carry flop, bit counter, sum_out and cout_out clear to 0.
  - busy=0 and done=0.
  - Reset mid-operation abandons the operation; no done pulse follows.
- States: IDLE, SHIFT, DONE; encoding is free.
- IDLE:
  - start=1 at an edge latches a_in, b_in and cin_in into a_sh, b_sh and carry_q.
  - The same edge clears the bit counter and the sum shift register, and moves to SHIFT.
  - start=0 stays in IDLE.
- SHIFT:
  - Combinational outputs: fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry_q.
  - Each edge: a_sh and b_sh shift right by 1 with zero fill.
  - Each edge: the sum register shifts right with fa_sum entering at the MSB.
  - Each edge: carry_q<=fa_cout and the counter increments.
  - The edge on which counter==WIDTH-1 moves to DONE. The state occupies exactly WIDTH cycles.
- DONE:
  - done=1 for exactly one cycle.
  - sum_out and cout_out are registered on the edge that entered DONE, so they are valid in the same cycle as done.
  - Next edge goes unconditionally to IDLE.
- Outside SHIFT, fa_a, fa_b and fa_cin are driven 0.
- busy=1 only in SHIFT.
- Latency: start accepted at edge k gives done high in the cycle following edge k+WIDTH. Throughput is one addition per WIDTH+2 cycles.
- start while busy or in DONE is ignored; the in-flight operands are unaffected. It is not queued.
- start in the same cycle as rst_n=0: reset wins.
- Arithmetic: {cout_out,sum_out} = a_in + b_in + cin_in, modulo 2^(WIDTH+1), evaluated with the latched values. Later input changes are irrelevant.
- Counter width: $clog2(WIDTH). No wrap occurs because SHIFT exits at WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADD_CHECK_EN.
- Defined:
  - Adds output port err (1 bit).
  - On the DONE transition, the block compares {fa_cout at final bit, collected sum} against an internal parallel add of the latched operands and carry-in.
  - On mismatch, err=1 and stays sticky until the next accepted start or reset.
  - Reset value of err is 0.
- Not defined:
  - err port, parallel adder and operand copies are absent.
  - All other behaviour is identical.

Test Plan (WIDTH=8):
- Reset: hold rst_n=0 for 2 edges with start=1 -> busy=0, done=0, sum_out=8'h00, cout_out=0, fa_a=fa_b=fa_cin=0; no operation starts.
- Basic add: a_in=8'h0F, b_in=8'h01, cin_in=0, start pulse -> busy high 8 cycles, then done=1 for 1 cycle with sum_out=8'h10, cout_out=0.
- Carry boundaries, in sequence:
  - a=8'hFF, b=8'h01, cin=0 -> sum_out=8'h00, cout_out=1.
  - a=8'hFF, b=8'hFF, cin=1 -> sum_out=8'hFF, cout_out=1.
  - a=8'h00, b=8'h00, cin=1 -> sum_out=8'h01, cout_out=0.
- Serial bit order: a=8'hA5, b=8'h5A, cin=0:
  - fa_a across SHIFT cycles = 1,0,1,0,0,1,0,1.
  - fa_b = 0,1,0,1,1,0,1,0.
  - fa_cin always 0.
  - Result sum_out=8'hFF, cout_out=0.
- Ignored start: launch a=8'h12, b=8'h34. Assert start with a=8'hFF, b=8'hFF on SHIFT cycle 3 -> result 8'h46, cout_out=0; the block returns to IDLE and no second operation runs.
- Reset mid-op: start a=8'h80, b=8'h80, then rst_n=0 on SHIFT cycle 4 -> next edge busy=0, sum_out=8'h00, cout_out=0; done never pulses.
- With SERIAL_ADD_CHECK_EN: correct full_adder -> err stays 0 over all cases above. Bench inverts fa_sum -> err=1 after done, cleared by the next start.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add sequencer feeding an external combinational
// full adder one operand bit pair per cycle, LSB first.
//
// Optional feature macro: SERIAL_ADD_CHECK_EN (adds a parallel-add cross-check
// and the sticky err output).
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   start               begin an addition (sampled only in IDLE)
//   a_in, b_in, cin_in  operands and carry-in, latched when start is accepted
//   fa_a, fa_b, fa_cin  to the full adder (0 outside SHIFT)
//   fa_sum, fa_cout     from the full adder
//   busy                high in SHIFT
//   done                one-cycle pulse, result valid
//   sum_out, cout_out   WIDTH-bit sum and carry-out, held until overwritten
//   err                 (SERIAL_ADD_CHECK_EN only) sticky cross-check failure
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
`ifdef SERIAL_ADD_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned SW = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic [WIDTH-1:0] sum_next;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    // Full adder's sum enters at the MSB so the LSB-first stream lands in order.
    assign sum_next = {fa_sum, sum_sh[WIDTH-1:1]};

    // Adder drive is live only while shifting.
    assign fa_a   = (state == SHIFT) ? a_sh[0] : 1'b0;
    assign fa_b   = (state == SHIFT) ? b_sh[0] : 1'b0;
    assign fa_cin = (state == SHIFT) ? carry_q : 1'b0;

`ifdef SERIAL_ADD_CHECK_EN
    logic [WIDTH-1:0] a_cp;
    logic [WIDTH-1:0] b_cp;
    logic             c_cp;
    logic [SW-1:0]    ref_sum;

    assign ref_sum = SW'(a_cp) + SW'(b_cp) + SW'(c_cp);
`endif

    // Sequencer: state, datapath registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            carry_q  <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum_out  <= '0;
            cout_out <= 1'b0;
`ifdef SERIAL_ADD_CHECK_EN
            a_cp     <= '0;
            b_cp     <= '0;
            c_cp     <= 1'b0;
            err      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SHIFT;
                        a_sh    <= a_in;
                        b_sh    <= b_in;
                        carry_q <= cin_in;
                        sum_sh  <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
`ifdef SERIAL_ADD_CHECK_EN
                        a_cp    <= a_in;
                        b_cp    <= b_in;
                        c_cp    <= cin_in;
                        err     <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    sum_sh  <= sum_next;
                    carry_q <= fa_cout;
                    cnt     <= cnt + CW'(1);
                    if (last_bit) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum_out  <= sum_next;
                        cout_out <= fa_cout;
`ifdef SERIAL_ADD_CHECK_EN
                        if ({fa_cout, sum_next} != ref_sum) begin
                            err <= 1'b1;
                        end
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
